ball_ctl: RTL

//  Ball motion controller; sits directly upstream of the brick collision detector.

---
 rtl/ball_ctl_if.sv | 22 ++
 rtl/ball_ctl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ball_ctl_if.sv
// Ball controller handshake bundle: frame/serve/paddle/collision inputs and ball
// position/status outputs. The controller is the slave; its driver is the master.
interface ball_ctl_if;
  logic        frame_tick;
  logic        start;
  logic [11:0] paddle_x;
  logic        collision_det;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        ball_lost;
  logic        game_over;

  modport master (
    output frame_tick, start, paddle_x, collision_det,
    input  x_pos, y_pos, ball_lost, game_over
  );

  modport slave (
    input  frame_tick, start, paddle_x, collision_det,
    output x_pos, y_pos, ball_lost, game_over
  );
endinterface

// File: rtl/ball_ctl.sv
// Ball motion controller: walls, paddle bounce, brick-collision flip, serve and loss.
// Optional lives counter / game-over state enabled by defining BALL_LIVES_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | ball parked on paddle, follows paddle each frame, waits for start
// S_MOVE    | ball in flight, one STEP per frame_tick on each axis
// S_LOST    | one-cycle ball_lost pulse after passing the floor
// S_OVER    | lives exhausted, ball frozen until reset (BALL_LIVES_EN only)
module ball_ctl #(
  parameter int H_MAX     = 800,
  parameter int V_MAX     = 600,
  parameter int BALL_SIZE = 10,
  parameter int STEP      = 1,
  parameter int PADDLE_Y  = 560,
  parameter int PADDLE_W  = 80,
  parameter int LIVES     = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  ball_ctl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_LOST, S_OVER} state_t;

  localparam int X_RST = H_MAX / 2 - BALL_SIZE / 2;

  // 14-bit signed working range covers paddle_x + PADDLE_W and negative steps
  localparam logic signed [13:0] C_STEP   = 14'(STEP);
  localparam logic signed [13:0] C_XMAX   = 14'(H_MAX - BALL_SIZE);
  localparam logic signed [13:0] C_YFLOOR = 14'(V_MAX - BALL_SIZE);
  localparam logic signed [13:0] C_YSERVE = 14'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [13:0] C_PY     = 14'(PADDLE_Y);
  localparam logic signed [13:0] C_PW     = 14'(PADDLE_W);
  localparam logic signed [13:0] C_BS     = 14'(BALL_SIZE);
  localparam logic signed [13:0] C_SOFS   = 14'(PADDLE_W / 2 - BALL_SIZE / 2);

  state_t      state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        dir_right_q, dir_right_d;
  logic        dir_down_q, dir_down_d;
  logic        coll_prev_q;
  logic        coll_pend_q, coll_pend_d;

  logic               coll_rise;
  logic               coll_take;
  logic signed [13:0] px_s;
  logic signed [13:0] serve_x;
  logic signed [13:0] nx;
  logic signed [13:0] ny;
  logic signed [13:0] x_mv;
  logic               dir_right_mv;
  logic               paddle_hit;

`ifdef BALL_LIVES_EN
  logic [2:0] lives_q, lives_d;
`endif

  assign coll_rise = bus.collision_det & ~coll_prev_q;
  assign coll_take = coll_pend_q | coll_rise;
  assign px_s      = $signed({2'b00, bus.paddle_x});
  assign serve_x   = px_s + C_SOFS;
  assign nx        = dir_right_q ? $signed({2'b00, x_q}) + C_STEP
                                 : $signed({2'b00, x_q}) - C_STEP;
  assign ny        = dir_down_q  ? $signed({2'b00, y_q}) + C_STEP
                                 : $signed({2'b00, y_q}) - C_STEP;

  always_comb begin
    x_mv         = nx;
    dir_right_mv = dir_right_q;
    if (nx < 14'sd0) begin
      x_mv         = 14'sd0;
      dir_right_mv = 1'b1;
    end else if (nx > C_XMAX) begin
      x_mv         = C_XMAX;
      dir_right_mv = 1'b0;
    end
  end

  // paddle test uses the wall-corrected x of this frame
  assign paddle_hit = dir_down_q && (ny + C_BS >= C_PY) && (ny < C_PY) &&
                      (x_mv < px_s + C_PW) && (x_mv + C_BS > px_s);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_right_d = dir_right_q;
    dir_down_d  = dir_down_q;
    coll_pend_d = coll_take;
`ifdef BALL_LIVES_EN
    lives_d     = lives_q;
`endif
    case (state_q)
      S_IDLE: begin
        coll_pend_d = 1'b0;
        if (bus.frame_tick) begin
          x_d = (serve_x > C_XMAX) ? C_XMAX[11:0] : serve_x[11:0];
          y_d = C_YSERVE[11:0];
          if (bus.start) begin
            state_d     = S_MOVE;
            dir_right_d = 1'b1;
            dir_down_d  = 1'b0;
          end
        end
      end
      S_MOVE: begin
        if (bus.frame_tick) begin
          coll_pend_d = 1'b0;
          if (ny <= 14'sd0) begin
            x_d         = x_mv[11:0];
            dir_right_d = dir_right_mv;
            y_d         = 12'd0;
            dir_down_d  = 1'b1;
          end else if (paddle_hit) begin
            x_d         = x_mv[11:0];
            dir_right_d = dir_right_mv;
            y_d         = C_YSERVE[11:0];
            dir_down_d  = 1'b0;
          end else if (ny >= C_YFLOOR) begin
            state_d = S_LOST;
          end else begin
            x_d         = x_mv[11:0];
            dir_right_d = dir_right_mv;
            y_d         = ny[11:0];
            if (coll_take) dir_down_d = ~dir_down_q;
          end
        end
      end
      S_LOST: begin
        coll_pend_d = 1'b0;
`ifdef BALL_LIVES_EN
        lives_d = lives_q - 3'd1;
        state_d = (lives_q == 3'd1) ? S_OVER : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_OVER: begin
        coll_pend_d = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        coll_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= 12'(X_RST);
      y_q         <= C_YSERVE[11:0];
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b0;
      coll_prev_q <= 1'b0;
      coll_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_right_q <= dir_right_d;
      dir_down_q  <= dir_down_d;
      coll_prev_q <= bus.collision_det;
      coll_pend_q <= coll_pend_d;
    end
  end

`ifdef BALL_LIVES_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) lives_q <= 3'(LIVES);
    else        lives_q <= lives_d;
  end
  assign bus.game_over = (state_q == S_OVER);
`else
  assign bus.game_over = 1'b0;
`endif

  assign bus.x_pos     = x_q;
  assign bus.y_pos     = y_q;
  assign bus.ball_lost = (state_q == S_LOST);

endmodule
